// File: rtl/detector_pkg.sv
// -----------------------------------------------------------------------------
// detector_pkg
// Shared definitions for the detector profile scheduler:
//   X_W / S_W       coordinate and pixel-count widths used by the detector
//   VGA_LINES       visible lines per frame of the video timing in use
//   sched_state_t   scheduler states
//   prof_cfg_t      one detection profile's window/threshold set
//   hist_push()     shifts a result into a 2-entry history
//   deb_level()     debounced level from a 2-entry history and previous level
// -----------------------------------------------------------------------------
package detector_pkg;

    localparam int X_W       = 11;
    localparam int S_W       = 18;
    localparam int VGA_LINES = 480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [X_W-1:0] xmin;
        logic [X_W-1:0] xmax;
        logic [X_W-1:0] y_thresh;
        logic [S_W-1:0] thresh;
        logic [S_W-1:0] thresh2;
    } prof_cfg_t;

    // Oldest result drops out, newest enters at bit 0.
    function automatic logic [1:0] hist_push(input logic [1:0] hist, input logic bit_in);
        return {hist[0], bit_in};
    endfunction

    // Level changes only when both history entries agree; otherwise it holds.
    function automatic logic deb_level(input logic [1:0] hist, input logic prev);
        logic lvl;
        case (hist)
            2'b11:   lvl = 1'b1;
            2'b00:   lvl = 1'b0;
            default: lvl = prev;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/detector_sched_if.sv
// -----------------------------------------------------------------------------
// detector_sched_if
// Bundles the profile configuration write bus and the link to the frame-based
// pixel detector.
//   master : the scheduler; receives config writes and detector results, drives
//            the detector window/thresholds and the colour-matcher select
//   slave  : the environment (config writer + detector + colour matcher)
// Signals:
//   cfg_we, cfg_ch, cfg_xmin, cfg_xmax, cfg_y_thresh, cfg_thresh, cfg_thresh2
//   new_frame, found, found2
//   XMIN, XMAX, y_thresh, frame_thresh, frame_thresh2, det_sel
// -----------------------------------------------------------------------------
interface detector_sched_if #(
    parameter int CH_W = 2,
    parameter int X_W  = 11,
    parameter int S_W  = 18
) ();

    logic            cfg_we;
    logic [CH_W-1:0] cfg_ch;
    logic [X_W-1:0]  cfg_xmin;
    logic [X_W-1:0]  cfg_xmax;
    logic [X_W-1:0]  cfg_y_thresh;
    logic [S_W-1:0]  cfg_thresh;
    logic [S_W-1:0]  cfg_thresh2;

    logic            new_frame;
    logic            found;
    logic            found2;

    logic [X_W-1:0]  XMIN;
    logic [X_W-1:0]  XMAX;
    logic [X_W-1:0]  y_thresh;
    logic [S_W-1:0]  frame_thresh;
    logic [S_W-1:0]  frame_thresh2;
    logic [CH_W-1:0] det_sel;

    modport master (
        input  cfg_we, cfg_ch, cfg_xmin, cfg_xmax, cfg_y_thresh, cfg_thresh, cfg_thresh2,
        input  new_frame, found, found2,
        output XMIN, XMAX, y_thresh, frame_thresh, frame_thresh2, det_sel
    );

    modport slave (
        output cfg_we, cfg_ch, cfg_xmin, cfg_xmax, cfg_y_thresh, cfg_thresh, cfg_thresh2,
        output new_frame, found, found2,
        input  XMIN, XMAX, y_thresh, frame_thresh, frame_thresh2, det_sel
    );

endinterface

// File: rtl/detector_sched_rr_next_ch.sv
// -----------------------------------------------------------------------------
// rr_next_ch
// Combinational round-robin search: the next enabled index strictly above
// 'cur', wrapping through 0, with 'cur' itself as the last candidate (so a
// single enabled profile maps onto itself).
//   mask  in  NUM_CH  enable mask
//   cur   in  CH_W    current index
//   nxt   out CH_W    next enabled index (cur when none enabled)
//   none  out 1       no bit of mask set
// -----------------------------------------------------------------------------
module rr_next_ch #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    output logic [CH_W-1:0]   nxt,
    output logic              none
);

    logic [CH_W-1:0] idx_s;

    // Walk candidates from farthest to nearest so the nearest enabled one wins.
    always_comb begin
        nxt   = cur;
        idx_s = cur;
        none  = (mask == {NUM_CH{1'b0}});
        for (int k = NUM_CH; k >= 1; k--) begin
            idx_s = CH_W'((int'(cur) + k) % NUM_CH);
            if (mask[idx_s]) begin
                nxt = idx_s;
            end else begin
                nxt = nxt;
            end
        end
    end

endmodule

// File: rtl/detector_sched.sv
// -----------------------------------------------------------------------------
// detector_sched
// Time-multiplexes one frame-based pixel detector across NUM_CH detection
// profiles, one profile per video frame in round-robin order over the enabled
// profiles, and latches each profile's found/found2 at its frame boundary.
//
// Ports:
//   clock         system/pixel clock
//   reset_n       asynchronous active-low reset
//   clken         pixel enable; nothing advances while low
//   ch_enable     per-profile enable mask
//   bus           detector_sched_if.master: config writes, detector link
//   ch_found      latched per-profile found results
//   ch_found2     latched per-profile found2 results
//   result_valid  one-cycle pulse when a profile result is written
//   busy          high whenever the scheduler is not IDLE
//
// Build option: DETECTOR_SCHED_DEBOUNCE_EN -- when defined, ch_found/ch_found2
// bits change only after two consecutive equal results for that profile.
//
// The active window/thresholds/select change on the clken cycle after
// new_frame, so the detector sees the new profile from pixel (2,1); profile
// windows therefore need xmin >= 2.
// -----------------------------------------------------------------------------
module detector_sched #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int X_W    = detector_pkg::X_W,
    parameter int S_W    = detector_pkg::S_W
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clken,
    input  logic [NUM_CH-1:0]    ch_enable,
    detector_sched_if.master     bus,
    output logic [NUM_CH-1:0]    ch_found,
    output logic [NUM_CH-1:0]    ch_found2,
    output logic                 result_valid,
    output logic                 busy
);

    import detector_pkg::*;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    sched_state_t    state_r;
    logic            busy_r;
    logic [CH_W-1:0] ptr_r;
    logic [X_W-1:0]  xmin_r;
    logic [X_W-1:0]  xmax_r;
    logic [X_W-1:0]  y_thresh_r;
    logic [S_W-1:0]  thresh_r;
    logic [S_W-1:0]  thresh2_r;
    logic [NUM_CH-1:0] ch_found_r;
    logic [NUM_CH-1:0] ch_found2_r;
    logic            result_valid_r;

    prof_cfg_t       shadow_r [NUM_CH];
    prof_cfg_t       wr_cfg_s;
    prof_cfg_t       load_cfg_s;

    logic [CH_W-1:0] rr_cur_s;
    logic [CH_W-1:0] nxt_ch_s;
    logic            none_s;
    logic [CH_W-1:0] load_ch_s;
    logic            cur_en_s;
    logic            commit_s;
    logic [NUM_CH-1:0] found_upd_s;
    logic [NUM_CH-1:0] found2_upd_s;

`ifdef DETECTOR_SCHED_DEBOUNCE_EN
    logic [1:0]      hist_r  [NUM_CH];
    logic [1:0]      hist2_r [NUM_CH];
    logic [1:0]      hist_new_s;
    logic [1:0]      hist2_new_s;
`endif

    // From IDLE the search starts at the top index so it lands on the lowest
    // enabled profile; otherwise it continues from the active profile.
    always_comb begin
        if (state_r == IDLE) begin
            rr_cur_s = LAST_CH;
        end else begin
            rr_cur_s = ptr_r;
        end
    end

    rr_next_ch #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_next_ch (
        .mask (ch_enable),
        .cur  (rr_cur_s),
        .nxt  (nxt_ch_s),
        .none (none_s)
    );

    assign cur_en_s = ch_enable[ptr_r];
    assign commit_s = (state_r == RUN) && bus.new_frame && cur_en_s && !none_s;

    // Profile to load at the next boundary, and its config with a same-cycle
    // write folded in so that write is not lost.
    always_comb begin
        wr_cfg_s.xmin     = bus.cfg_xmin;
        wr_cfg_s.xmax     = bus.cfg_xmax;
        wr_cfg_s.y_thresh = bus.cfg_y_thresh;
        wr_cfg_s.thresh   = bus.cfg_thresh;
        wr_cfg_s.thresh2  = bus.cfg_thresh2;
        case (state_r)
            IDLE:    load_ch_s = nxt_ch_s;
            SYNC:    load_ch_s = cur_en_s ? ptr_r : nxt_ch_s;
            RUN:     load_ch_s = nxt_ch_s;
            default: load_ch_s = ptr_r;
        endcase
        if (bus.cfg_we && (bus.cfg_ch == load_ch_s)) begin
            load_cfg_s = wr_cfg_s;
        end else begin
            load_cfg_s = shadow_r[load_ch_s];
        end
    end

    // Result vectors as they become at a boundary; disabled profiles read 0.
    always_comb begin
        found_upd_s  = ch_found_r;
        found2_upd_s = ch_found2_r;
`ifdef DETECTOR_SCHED_DEBOUNCE_EN
        hist_new_s  = hist_push(hist_r[ptr_r], bus.found);
        hist2_new_s = hist_push(hist2_r[ptr_r], bus.found2);
        if (cur_en_s) begin
            found_upd_s[ptr_r]  = deb_level(hist_new_s, ch_found_r[ptr_r]);
            found2_upd_s[ptr_r] = deb_level(hist2_new_s, ch_found2_r[ptr_r]);
        end else begin
            found_upd_s  = ch_found_r;
            found2_upd_s = ch_found2_r;
        end
`else
        if (cur_en_s) begin
            found_upd_s[ptr_r]  = bus.found;
            found2_upd_s[ptr_r] = bus.found2;
        end else begin
            found_upd_s  = ch_found_r;
            found2_upd_s = ch_found2_r;
        end
`endif
        found_upd_s  = found_upd_s & ch_enable;
        found2_upd_s = found2_upd_s & ch_enable;
    end

    // Per-profile shadow config; written at any time, read only at selection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_r[i] <= {$bits(prof_cfg_t){1'b0}};
            end
        end else if (clken && bus.cfg_we && (int'(bus.cfg_ch) < NUM_CH)) begin
            shadow_r[bus.cfg_ch] <= wr_cfg_s;
        end
    end

    // Scheduler FSM with pointer, active config, result latches and pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            busy_r         <= 1'b0;
            ptr_r          <= {CH_W{1'b0}};
            xmin_r         <= {X_W{1'b0}};
            xmax_r         <= {X_W{1'b0}};
            y_thresh_r     <= {X_W{1'b0}};
            thresh_r       <= {S_W{1'b0}};
            thresh2_r      <= {S_W{1'b0}};
            ch_found_r     <= {NUM_CH{1'b0}};
            ch_found2_r    <= {NUM_CH{1'b0}};
            result_valid_r <= 1'b0;
        end else if (clken) begin
            result_valid_r <= 1'b0;
            if (none_s) begin
                // All profiles off: park, keep the detector outputs as they are.
                state_r     <= IDLE;
                busy_r      <= 1'b0;
                ch_found_r  <= {NUM_CH{1'b0}};
                ch_found2_r <= {NUM_CH{1'b0}};
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r    <= SYNC;
                        busy_r     <= 1'b1;
                        ptr_r      <= load_ch_s;
                        xmin_r     <= load_cfg_s.xmin;
                        xmax_r     <= load_cfg_s.xmax;
                        y_thresh_r <= load_cfg_s.y_thresh;
                        thresh_r   <= load_cfg_s.thresh;
                        thresh2_r  <= load_cfg_s.thresh2;
                    end
                    SYNC: begin
                        // The partial first frame ends here; its result is dropped.
                        if (bus.new_frame) begin
                            state_r    <= RUN;
                            ptr_r      <= load_ch_s;
                            xmin_r     <= load_cfg_s.xmin;
                            xmax_r     <= load_cfg_s.xmax;
                            y_thresh_r <= load_cfg_s.y_thresh;
                            thresh_r   <= load_cfg_s.thresh;
                            thresh2_r  <= load_cfg_s.thresh2;
                        end
                    end
                    RUN: begin
                        if (bus.new_frame) begin
                            ptr_r          <= load_ch_s;
                            xmin_r         <= load_cfg_s.xmin;
                            xmax_r         <= load_cfg_s.xmax;
                            y_thresh_r     <= load_cfg_s.y_thresh;
                            thresh_r       <= load_cfg_s.thresh;
                            thresh2_r      <= load_cfg_s.thresh2;
                            ch_found_r     <= found_upd_s;
                            ch_found2_r    <= found2_upd_s;
                            result_valid_r <= cur_en_s;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef DETECTOR_SCHED_DEBOUNCE_EN
    // Debounce histories; wiped for any profile that is (or goes) disabled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                hist_r[i]  <= 2'b00;
                hist2_r[i] <= 2'b00;
            end
        end else if (clken) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!ch_enable[i]) begin
                    hist_r[i]  <= 2'b00;
                    hist2_r[i] <= 2'b00;
                end else if (commit_s && (ptr_r == CH_W'(i))) begin
                    hist_r[i]  <= hist_new_s;
                    hist2_r[i] <= hist2_new_s;
                end
            end
        end
    end
`else
    logic unused_commit_s;
    assign unused_commit_s = commit_s;
`endif

    assign bus.XMIN          = xmin_r;
    assign bus.XMAX          = xmax_r;
    assign bus.y_thresh      = y_thresh_r;
    assign bus.frame_thresh  = thresh_r;
    assign bus.frame_thresh2 = thresh2_r;
    assign bus.det_sel       = ptr_r;
    assign ch_found          = ch_found_r;
    assign ch_found2         = ch_found2_r;
    assign result_valid      = result_valid_r;
    assign busy              = busy_r;

endmodule

// File: tb/tb_detector_sched.sv
// Directed bench for detector_sched (NUM_CH=4). Expected values are worked out
// by hand from the scheduling rules and written as constants.
module tb_detector_sched;

    logic       clock;
    logic       reset_n;
    logic       clken;
    logic [3:0] ch_enable;
    logic [3:0] ch_found;
    logic [3:0] ch_found2;
    logic       result_valid;
    logic       busy;

    int tests_run;
    int tests_failed;

    detector_sched_if #(.CH_W(2), .X_W(11), .S_W(18)) bus ();

    detector_sched #(
        .NUM_CH (4),
        .CH_W   (2),
        .X_W    (11),
        .S_W    (18)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .clken        (clken),
        .ch_enable    (ch_enable),
        .bus          (bus),
        .ch_found     (ch_found),
        .ch_found2    (ch_found2),
        .result_valid (result_valid),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_frame(input logic f, input logic f2);
        bus.new_frame = 1'b1;
        bus.found     = f;
        bus.found2    = f2;
        tick(1);
        bus.new_frame = 1'b0;
        bus.found     = 1'b0;
        bus.found2    = 1'b0;
    endtask

    task automatic write_cfg(input logic [1:0] ch, input logic [10:0] xmin, input logic [10:0] xmax,
                             input logic [10:0] yth, input logic [17:0] th, input logic [17:0] th2);
        bus.cfg_we       = 1'b1;
        bus.cfg_ch       = ch;
        bus.cfg_xmin     = xmin;
        bus.cfg_xmax     = xmax;
        bus.cfg_y_thresh = yth;
        bus.cfg_thresh   = th;
        bus.cfg_thresh2  = th2;
        tick(1);
        bus.cfg_we       = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(2);
        tests_run++;
        if ({bus.XMIN, bus.XMAX, bus.y_thresh, bus.frame_thresh, bus.frame_thresh2, bus.det_sel} !== 71'd0) begin
            tests_failed++;
            $display("FAIL reset_det_outputs: got %h want 0", {bus.XMIN, bus.XMAX, bus.y_thresh, bus.frame_thresh, bus.frame_thresh2, bus.det_sel});
        end
        tests_run++;
        if ({ch_found, ch_found2, result_valid, busy} !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_results: got %b want 0", {ch_found, ch_found2, result_valid, busy});
        end
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_basic();
        write_cfg(2'd0, 11'd5, 11'd300, 11'd40, 18'd100, 18'd50);
        ch_enable = 4'b0101;
        tick(1);
        tests_run++;
        if (busy !== 1'b1 || bus.det_sel !== 2'd0) begin
            tests_failed++;
            $display("FAIL basic_enter: busy=%b det_sel=%0d want busy=1 det_sel=0", busy, bus.det_sel);
        end
        tests_run++;
        if (bus.XMIN !== 11'd5 || bus.frame_thresh !== 18'd100) begin
            tests_failed++;
            $display("FAIL basic_cfg_load: XMIN=%0d thresh=%0d want 5/100", bus.XMIN, bus.frame_thresh);
        end
        tick(3);
        pulse_frame(1'b1, 1'b0);
        tests_run++;
        if (result_valid !== 1'b0 || ch_found !== 4'b0000 || bus.det_sel !== 2'd0) begin
            tests_failed++;
            $display("FAIL basic_sync_discard: rv=%b ch_found=%b det_sel=%0d want 0/0000/0", result_valid, ch_found, bus.det_sel);
        end
        tick(3);
        pulse_frame(1'b1, 1'b1);
        tests_run++;
        if (result_valid !== 1'b1 || ch_found !== 4'b0001 || ch_found2 !== 4'b0001 || bus.det_sel !== 2'd2) begin
            tests_failed++;
            $display("FAIL basic_first_result: rv=%b ch_found=%b ch_found2=%b det_sel=%0d want 1/0001/0001/2",
                     result_valid, ch_found, ch_found2, bus.det_sel);
        end
        tick(1);
        tests_run++;
        if (result_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_rv_pulse_width: rv=%b want 0", result_valid);
        end
        pulse_frame(1'b0, 1'b0);
        tests_run++;
        if (bus.det_sel !== 2'd0 || ch_found !== 4'b0001) begin
            tests_failed++;
            $display("FAIL basic_wrap: det_sel=%0d ch_found=%b want 0/0001", bus.det_sel, ch_found);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_sel;
        ch_enable = 4'b0000;
        tick(1);
        ch_enable = 4'b1111;
        tick(1);
        pulse_frame(1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            exp_sel = 2'(k % 4);
            tests_run++;
            if (bus.det_sel !== exp_sel) begin
                tests_failed++;
                $display("FAIL rr_det_sel[%0d]: got %0d want %0d", k, bus.det_sel, exp_sel);
            end
            tick(2);
            pulse_frame((k % 2) == 0, 1'b0);
        end
        tests_run++;
        if (ch_found !== 4'b0101 || bus.det_sel !== 2'd0) begin
            tests_failed++;
            $display("FAIL rr_found: ch_found=%b det_sel=%0d want 0101/0", ch_found, bus.det_sel);
        end
    endtask

    task automatic test_cfg_shadow();
        write_cfg(2'd1, 11'd10, 11'd600, 11'd7, 18'd1234, 18'd99);
        pulse_frame(1'b1, 1'b0);
        tests_run++;
        if (bus.det_sel !== 2'd1 || bus.XMIN !== 11'd10 || bus.XMAX !== 11'd600 ||
            bus.y_thresh !== 11'd7 || bus.frame_thresh !== 18'd1234 || bus.frame_thresh2 !== 18'd99) begin
            tests_failed++;
            $display("FAIL cfg_select: sel=%0d XMIN=%0d XMAX=%0d y=%0d t=%0d t2=%0d want 1/10/600/7/1234/99",
                     bus.det_sel, bus.XMIN, bus.XMAX, bus.y_thresh, bus.frame_thresh, bus.frame_thresh2);
        end
        write_cfg(2'd1, 11'd50, 11'd600, 11'd7, 18'd1234, 18'd99);
        tick(2);
        tests_run++;
        if (bus.XMIN !== 11'd10) begin
            tests_failed++;
            $display("FAIL cfg_midframe_hold: XMIN=%0d want 10", bus.XMIN);
        end
        repeat (3) pulse_frame(1'b1, 1'b0);
        tests_run++;
        if (bus.det_sel !== 2'd0 || bus.XMIN !== 11'd5) begin
            tests_failed++;
            $display("FAIL cfg_ch0_reload: sel=%0d XMIN=%0d want 0/5", bus.det_sel, bus.XMIN);
        end
        pulse_frame(1'b1, 1'b0);
        tests_run++;
        if (bus.det_sel !== 2'd1 || bus.XMIN !== 11'd50) begin
            tests_failed++;
            $display("FAIL cfg_new_value: sel=%0d XMIN=%0d want 1/50", bus.det_sel, bus.XMIN);
        end
        repeat (3) pulse_frame(1'b1, 1'b0);
        // Write landing on the same cycle as the boundary that selects profile 1.
        bus.cfg_we       = 1'b1;
        bus.cfg_ch       = 2'd1;
        bus.cfg_xmin     = 11'd77;
        pulse_frame(1'b1, 1'b0);
        bus.cfg_we       = 1'b0;
        tests_run++;
        if (bus.det_sel !== 2'd1 || bus.XMIN !== 11'd77) begin
            tests_failed++;
            $display("FAIL cfg_same_cycle: sel=%0d XMIN=%0d want 1/77", bus.det_sel, bus.XMIN);
        end
    endtask

    task automatic test_mask_change();
        pulse_frame(1'b1, 1'b0);
        tests_run++;
        if (bus.det_sel !== 2'd2 || ch_found !== 4'b1111) begin
            tests_failed++;
            $display("FAIL mask_pre: sel=%0d ch_found=%b want 2/1111", bus.det_sel, ch_found);
        end
        tick(2);
        ch_enable = 4'b1011;
        tick(2);
        pulse_frame(1'b1, 1'b1);
        tests_run++;
        if (result_valid !== 1'b0 || ch_found !== 4'b1011 || ch_found2 !== 4'b0000 || bus.det_sel !== 2'd3) begin
            tests_failed++;
            $display("FAIL mask_drop_active: rv=%b ch_found=%b ch_found2=%b sel=%0d want 0/1011/0000/3",
                     result_valid, ch_found, ch_found2, bus.det_sel);
        end
    endtask

    task automatic test_idle();
        tick(2);
        ch_enable = 4'b0000;
        tick(1);
        tests_run++;
        if (busy !== 1'b0 || ch_found !== 4'b0000 || ch_found2 !== 4'b0000 || bus.det_sel !== 2'd3) begin
            tests_failed++;
            $display("FAIL idle_enter: busy=%b ch_found=%b ch_found2=%b sel=%0d want 0/0000/0000/3",
                     busy, ch_found, ch_found2, bus.det_sel);
        end
        ch_enable = 4'b0001;
        tick(1);
        tests_run++;
        if (busy !== 1'b1 || bus.det_sel !== 2'd0) begin
            tests_failed++;
            $display("FAIL idle_reenable: busy=%b sel=%0d want 1/0", busy, bus.det_sel);
        end
        pulse_frame(1'b1, 1'b0);
        tests_run++;
        if (result_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_sync_discard: rv=%b want 0", result_valid);
        end
        pulse_frame(1'b1, 1'b0);
        tests_run++;
        if (result_valid !== 1'b1 || ch_found !== 4'b0001 || bus.det_sel !== 2'd0) begin
            tests_failed++;
            $display("FAIL idle_single_profile: rv=%b ch_found=%b sel=%0d want 1/0001/0", result_valid, ch_found, bus.det_sel);
        end
    endtask

    task automatic test_found_pattern();
        logic [5:0] pat;
        logic [5:0] exp;
        pat = 6'b001101;
`ifdef DETECTOR_SCHED_DEBOUNCE_EN
        exp = 6'b011000;
`else
        exp = 6'b001101;
`endif
        ch_enable = 4'b0000;
        tick(1);
        ch_enable = 4'b0001;
        tick(1);
        pulse_frame(1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick(2);
            pulse_frame(pat[k], 1'b0);
            tests_run++;
            if (ch_found[0] !== exp[k]) begin
                tests_failed++;
                $display("FAIL pattern_frame%0d: ch_found[0]=%b want %b", k + 1, ch_found[0], exp[k]);
            end
        end
    endtask

    task automatic test_clken_hold();
        logic [3:0] exp_found;
`ifdef DETECTOR_SCHED_DEBOUNCE_EN
        exp_found = 4'b0000;
`else
        exp_found = 4'b0001;
`endif
        bus.new_frame = 1'b1;
        bus.found     = 1'b1;
        tick(1);
        clken         = 1'b0;
        bus.found     = 1'b0;
        tick(3);
        tests_run++;
        if (result_valid !== 1'b1 || ch_found !== exp_found) begin
            tests_failed++;
            $display("FAIL clken_hold: rv=%b ch_found=%b want 1/%b", result_valid, ch_found, exp_found);
        end
        clken         = 1'b1;
        bus.new_frame = 1'b0;
        tick(1);
        tests_run++;
        if (result_valid !== 1'b0 || ch_found !== exp_found) begin
            tests_failed++;
            $display("FAIL clken_resume: rv=%b ch_found=%b want 0/%b", result_valid, ch_found, exp_found);
        end
    endtask

    task automatic test_reset_midframe();
        tick(2);
        tests_run++;
        if (bus.XMIN !== 11'd5 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pre: XMIN=%0d busy=%b want 5/1", bus.XMIN, busy);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (bus.XMIN !== 11'd0 || busy !== 1'b0 || bus.det_sel !== 2'd0 || result_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_async: XMIN=%0d busy=%b sel=%0d rv=%b want 0/0/0/0", bus.XMIN, busy, bus.det_sel, result_valid);
        end
        tick(1);
        reset_n = 1'b1;
        tick(1);
        tests_run++;
        if (busy !== 1'b1 || bus.XMIN !== 11'd0) begin
            tests_failed++;
            $display("FAIL rst_restart: busy=%b XMIN=%0d want 1/0", busy, bus.XMIN);
        end
        pulse_frame(1'b1, 1'b0);
        tests_run++;
        if (result_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_sync_discard: rv=%b want 0", result_valid);
        end
        pulse_frame(1'b1, 1'b0);
        tests_run++;
        if (result_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_first_result: rv=%b want 1", result_valid);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        reset_n          = 1'b0;
        clken            = 1'b1;
        ch_enable        = 4'b0000;
        bus.cfg_we       = 1'b0;
        bus.cfg_ch       = 2'd0;
        bus.cfg_xmin     = 11'd0;
        bus.cfg_xmax     = 11'd0;
        bus.cfg_y_thresh = 11'd0;
        bus.cfg_thresh   = 18'd0;
        bus.cfg_thresh2  = 18'd0;
        bus.new_frame    = 1'b0;
        bus.found        = 1'b0;
        bus.found2       = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_round_robin();
        test_cfg_shadow();
        test_mask_change();
        test_idle();
        test_found_pattern();
        test_clken_hold();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/detector_sched.md
Name: detector_sched

Overview:
- Time-multiplexes the single frame-based pixel detector across NUM_CH detection profiles (e.g. goomba, pipe, bar), one profile per video frame, in round-robin order.
- Drives the detector's window/threshold inputs and a profile-select line to the colour matcher.
- Latches found/found2 per profile at each frame boundary and presents a stable per-profile result vector to game logic.

Parameters:
- NUM_CH, 4, number of profiles (2..8).
- CH_W, 2, width of channel index, equal to clog2(NUM_CH).
- X_W, 11, width of X/Y coordinate fields.
- S_W, 18, width of pixel-count thresholds; matches the detector sum width.

Ports:
- clock  in  1  system/pixel clock
- reset_n  in  1  asynchronous active-low reset
- clken  in  1  pixel enable; all state advances only when high
- ch_enable  in  NUM_CH  per-profile enable mask
- cfg_we  in  1  config write strobe (qualified by clken)
- cfg_ch  in  CH_W  profile being written
- cfg_xmin, cfg_xmax  in  X_W each  window bounds
- cfg_y_thresh  in  X_W  Y threshold
- cfg_thresh, cfg_thresh2  in  S_W each  frame count thresholds
- new_frame  in  1  detector frame-boundary pulse; found/found2 are valid in the same cycle
- found, found2  in  1 each  detector results
- XMIN, XMAX  out  X_W each  to detector
- y_thresh  out  X_W  to detector
- frame_thresh, frame_thresh2  out  S_W each  to detector
- det_sel  out  CH_W  active profile, to colour matcher
- ch_found, ch_found2  out  NUM_CH each  latched per-profile results
- result_valid  out  1  one-cycle pulse when a profile result is written
- busy  out  1  high when not IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, every shadow/active config register 0, channel pointer 0.
- States:
  - IDLE: ch_enable == 0. Outputs hold; ch_found and ch_found2 are cleared.
  - SYNC: the first frame after leaving IDLE is partial, so its result is discarded.
  - RUN: normal round-robin operation.
- IDLE → SYNC: when any ch_enable bit is set. The pointer loads the lowest enabled index and the active config loads immediately.
- SYNC → RUN: on the next new_frame. No result is written.
- RUN, on new_frame:
  - Write found/found2 into bit [det_sel] of ch_found/ch_found2.
  - Pulse result_valid.
  - Advance the pointer to the next enabled index above det_sel, wrapping to 0.
  - If only one profile is enabled, the pointer stays.
- Output timing: XMIN, XMAX, y_thresh, frame_thresh, frame_thresh2 and det_sel update one clken cycle after new_frame. The detector therefore sees the new profile from pixel (2,1). Software must program xmin ≥ 2.
- Config writes:
  - Go to a per-profile shadow register set.
  - Shadow is copied to the active outputs only when that profile is next selected, so a mid-frame write never alters the frame in progress.
  - A write on the same cycle as the selecting new_frame is included.
- Mask changes:
  - ch_enable bit cleared for the current profile mid-frame: the frame's result is discarded (no result_valid) and the pointer advances at the boundary.
  - Disabled profiles have their ch_found/ch_found2 bits forced to 0 at the next boundary.
  - ch_enable going to 0 from any state: IDLE at the next clken cycle.
- clken low: full state hold, including the result_valid register.
- Reset asserted mid-frame: immediate return to reset values. The next run begins in SYNC.

Optional Feature:
- Macro: DETECTOR_SCHED_DEBOUNCE_EN.
- Defined:
  - Each profile keeps a 2-bit history of found.
  - ch_found[i] sets only after two consecutive found=1 results for profile i, and clears only after two consecutive 0 results.
  - found2 is debounced the same way.
  - History is reset on entering IDLE or on profile disable.
- Undefined: ch_found/ch_found2 take the single-frame result directly; no history registers.

Decomposition:
- Package detector_pkg:
  - Width constants X_W and S_W.
  - VGA_LINES = 480.
  - State enum {IDLE, SYNC, RUN}.
  - Profile config struct {xmin, xmax, y_thresh, thresh, thresh2}.
- Sub-module rr_next_ch (combinational): given mask and current index, returns next enabled index and a none-enabled flag.
- Shadow config array, FSM and result latches stay in detector_sched.

Test Plan:
- Reset then ch_enable=4'b0101:
  - busy=1 and det_sel=0.
  - First new_frame gives no result_valid.
  - Second new_frame with found=1: ch_found=4'b0001, result_valid pulse, det_sel→2 one cycle later.
- Mask 4'b1111 over 8 frames:
  - det_sel sequence 0,1,2,3,0,1,2,3.
  - found toggling 1,0,1,0,… gives ch_found=4'b0101.
- Mid-frame config write to the active profile 1 (xmin 10→50): XMIN stays 10 until frame end and reads 50 when profile 1 is next selected.
- Clear the enable bit of the active profile 2 mid-frame: no result_valid at that boundary, ch_found[2]=0, det_sel skips to 3.
- Drop ch_enable to 0 during RUN: IDLE next cycle, busy=0, ch_found=0. Re-enable: the first frame is discarded (SYNC).
- With DETECTOR_SCHED_DEBOUNCE_EN, single profile, found pattern 1,0,1,1,0,0:
  - ch_found[0] rises after the 4th frame.
  - ch_found[0] falls after the 6th frame.
